// File: rtl/fq_pkg.sv
// Shared types and decode helpers for the fetch queue.
// Holds the fetch FSM state encoding, the queue entry layout and the
// J/B immediate extraction used by the predecoder.
package fq_pkg;

    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        MISS   = 2'd1,
        DRAIN  = 2'd2,
        HALT   = 2'd3
    } fq_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic        pred_taken;
    } fq_entry_t;

    // Sign-extended J-type immediate (bit 0 is always zero)
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate (bit 0 is always zero)
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fq_predecode.sv
// Combinational predecoder: classifies a fetched instruction and
// computes the predicted next fetch PC (32-bit wrapping arithmetic).
module fq_predecode
    import fq_pkg::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic        bht_taken_i,
    output logic [31:0] next_pc_o,
    output logic        pred_taken_o,
    output logic        is_branch_o,
    output logic        is_jalr_o
);

    logic [6:0] opcode;
    assign opcode = inst_i[6:0];

    // Pick the next PC: JAL always redirects, branches follow the BHT,
    // everything else (including JALR, which halts fetch) falls through.
    always_comb begin
        next_pc_o    = pc_i + 32'd4;
        pred_taken_o = 1'b0;
        is_branch_o  = 1'b0;
        is_jalr_o    = 1'b0;
        case (opcode)
            OP_JAL: begin
                next_pc_o    = pc_i + imm_j(inst_i);
                pred_taken_o = 1'b1;
            end
            OP_BRANCH: begin
                is_branch_o = 1'b1;
                if (bht_taken_i) begin
                    next_pc_o    = pc_i + imm_b(inst_i);
                    pred_taken_o = 1'b1;
                end
            end
            OP_JALR: begin
                is_jalr_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: probes the icache, falls back to the memory
// controller on a miss, predecodes/predicts and buffers DEPTH entries
// for dispatch. A flush during an outstanding miss drains the returning
// data; a JALR halts fetch until the next flush.
// Optional build macro FQ_PERF_EN adds saturating miss/full counters.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int          DEPTH     = 32,
    parameter int          BHT_IDX_W = 8,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic [31:0]                ic_addr,
    input  logic                       ic_hit,
    input  logic [31:0]                ic_inst,
    output logic                       ic_fill_en,
    output logic [31:0]                ic_fill_addr,
    output logic [31:0]                ic_fill_inst,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    input  logic                       mem_ready,
    input  logic [31:0]                mem_inst,
    output logic [BHT_IDX_W-1:0]       bht_index,
    input  logic                       bht_taken,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_inst,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_pred_pc,
    output logic                       deq_pred_taken,
    output logic [$clog2(DEPTH):0]     count
`ifdef FQ_PERF_EN
    ,
    output logic [31:0]                perf_miss_cnt,
    output logic [31:0]                perf_full_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fq_state_e        state_q, state_d;
    logic [31:0]      pc_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      mem_addr_q;
    fq_entry_t        queue_mem [DEPTH];

    logic        not_full;
    logic        probe;
    logic        enq;
    logic        deq;
    logic        miss_start;
    logic        fill;
    logic [31:0] fetch_inst;
    logic [31:0] pd_next_pc;
    logic        pd_pred_taken;
    logic        pd_is_branch;
    logic        pd_is_jalr;
    fq_entry_t   head_entry;
    logic        unused_sig;

    assign not_full  = (count_q != FULL_CNT);
    assign deq_valid = (count_q != '0);
    assign deq       = deq_valid && deq_ready && !flush;

    fq_predecode u_predecode (
        .inst_i       (fetch_inst),
        .pc_i         (pc_q),
        .bht_taken_i  (bht_taken),
        .next_pc_o    (pd_next_pc),
        .pred_taken_o (pd_pred_taken),
        .is_branch_o  (pd_is_branch),
        .is_jalr_o    (pd_is_jalr)
    );

    // Prediction for branches is already folded into pd_next_pc.
    assign unused_sig = pd_is_branch;

    // State register; rdy low freezes the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOOKUP;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over normal progress, and a request
    // still outstanding at flush time must be drained before refetching.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            if ((state_q == MISS || state_q == DRAIN) && !mem_ready) begin
                state_d = DRAIN;
            end else begin
                state_d = LOOKUP;
            end
        end else begin
            case (state_q)
                LOOKUP: begin
                    if (enq && pd_is_jalr) begin
                        state_d = HALT;
                    end else if (miss_start) begin
                        state_d = MISS;
                    end
                end
                MISS: begin
                    if (mem_ready) begin
                        state_d = pd_is_jalr ? HALT : LOOKUP;
                    end
                end
                DRAIN: begin
                    if (mem_ready) begin
                        state_d = LOOKUP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output/decision logic: probe, enqueue source, miss start and fill.
    always_comb begin
        probe      = 1'b0;
        enq        = 1'b0;
        miss_start = 1'b0;
        fill       = 1'b0;
        fetch_inst = ic_inst;
        case (state_q)
            LOOKUP: begin
                if (not_full) begin
                    probe = 1'b1;
                    if (ic_hit) begin
                        enq = !flush;
                    end else begin
                        miss_start = !flush;
                    end
                end
            end
            MISS: begin
                fetch_inst = mem_inst;
                if (mem_ready && !flush) begin
                    enq  = 1'b1;
                    fill = rdy;
                end
            end
            default: ;
        endcase
    end

    assign ic_addr      = probe ? pc_q : 32'h0;
    assign ic_fill_en   = fill;
    assign ic_fill_addr = fill ? pc_q : 32'h0;
    assign ic_fill_inst = fill ? mem_inst : 32'h0;
    assign mem_req      = (state_q == MISS) || (state_q == DRAIN);
    assign mem_addr     = mem_addr_q;
    assign bht_index    = pc_q[BHT_IDX_W+1:2];
    assign count        = count_q;

    // Fetch PC, queue pointers, occupancy and latched miss address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            mem_addr_q <= 32'h0;
        end else if (rdy) begin
            if (flush) begin
                pc_q    <= flush_pc;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (enq) begin
                    pc_q   <= pd_next_pc;
                    tail_q <= tail_q + PTR_W'(1);
                end
                if (deq) begin
                    head_q <= head_q + PTR_W'(1);
                end
                if (enq && !deq) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (!enq && deq) begin
                    count_q <= count_q - CNT_W'(1);
                end
                if (miss_start) begin
                    mem_addr_q <= pc_q;
                end
            end
        end
    end

    // Queue storage write; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && rdy && enq) begin
            queue_mem[tail_q] <= '{inst:       fetch_inst,
                                   pc:         pc_q,
                                   pred_pc:    pd_next_pc,
                                   pred_taken: pd_pred_taken};
        end
    end

    assign head_entry     = queue_mem[head_q];
    assign deq_inst       = deq_valid ? head_entry.inst       : 32'h0;
    assign deq_pc         = deq_valid ? head_entry.pc         : 32'h0;
    assign deq_pred_pc    = deq_valid ? head_entry.pred_pc    : 32'h0;
    assign deq_pred_taken = deq_valid ? head_entry.pred_taken : 1'b0;

`ifdef FQ_PERF_EN
    logic [31:0] perf_miss_q;
    logic [31:0] perf_full_q;

    // Saturating event counters; only reset clears them, never flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_miss_q <= 32'h0;
            perf_full_q <= 32'h0;
        end else if (rdy) begin
            if (miss_start && perf_miss_q != 32'hFFFF_FFFF) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end
            if (!not_full && perf_full_q != 32'hFFFF_FFFF) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
        end
    end

    assign perf_miss_cnt = perf_miss_q;
    assign perf_full_cnt = perf_full_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default parameters).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic [31:0] flush_pc;
    logic [31:0] ic_addr;
    logic        ic_hit;
    logic [31:0] ic_inst;
    logic        ic_fill_en;
    logic [31:0] ic_fill_addr, ic_fill_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_inst;
    logic [7:0]  bht_index;
    logic        bht_taken;
    logic        deq_valid, deq_ready;
    logic [31:0] deq_inst, deq_pc, deq_pred_pc;
    logic        deq_pred_taken;
    logic [5:0]  count;
`ifdef FQ_PERF_EN
    logic [31:0] perf_miss_cnt, perf_full_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] BEQ  = 32'h0000_0863; // beq x0,x0,+16
    localparam logic [31:0] JAL  = 32'hFF1F_F06F; // jal x0,-16
    localparam logic [31:0] JALR = 32'h0000_8067; // jalr x0,0(x1)

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .ic_addr        (ic_addr),
        .ic_hit         (ic_hit),
        .ic_inst        (ic_inst),
        .ic_fill_en     (ic_fill_en),
        .ic_fill_addr   (ic_fill_addr),
        .ic_fill_inst   (ic_fill_inst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_inst       (mem_inst),
        .bht_index      (bht_index),
        .bht_taken      (bht_taken),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_inst       (deq_inst),
        .deq_pc         (deq_pc),
        .deq_pred_pc    (deq_pred_pc),
        .deq_pred_taken (deq_pred_taken),
        .count          (count)
`ifdef FQ_PERF_EN
        ,
        .perf_miss_cnt  (perf_miss_cnt),
        .perf_full_cnt  (perf_full_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush = 1'b1; flush_pc = target; ic_hit = 1'b0; deq_ready = 1'b0; mem_ready = 1'b0;
        step();
        flush = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = 0; ic_hit = 0; ic_inst = 0;
        mem_ready = 0; mem_inst = 0; bht_taken = 0; deq_ready = 0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got %b want 0", deq_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (ic_addr !== 32'h0) begin errors++; $display("FAIL reset_ic_addr got %h want 0", ic_addr); end
        checks++; if (ic_fill_en !== 1'b0) begin errors++; $display("FAIL reset_fill_en got %b want 0", ic_fill_en); end
        checks++; if (deq_inst !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL reset_zero_outs got inst=%h maddr=%h want 0", deq_inst, mem_addr); end
        $display("test_reset done");
    endtask

    task automatic test_fill();
        ic_hit = 1'b1; ic_inst = NOP; deq_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++; if (ic_addr !== 32'(i * 4)) begin errors++; $display("FAIL fill_probe[%0d] got %h want %h", i, ic_addr, i * 4); end
            step();
        end
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL fill_count got %0d want 32", count); end
        checks++; if (deq_pc !== 32'h0 || deq_inst !== NOP || deq_pred_pc !== 32'h4) begin errors++; $display("FAIL fill_head got pc=%h inst=%h pred=%h want 0/%h/4", deq_pc, deq_inst, deq_pred_pc, NOP); end
        step(); step();
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_hold_count got %0d want 32", count); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_no_req got %b want 0", mem_req); end
        $display("test_fill done count=%0d", count);
    endtask

    task automatic test_full_wrap();
        deq_ready = 1'b1; ic_hit = 1'b1; ic_inst = NOP;
        #1;
        checks++; if (ic_addr !== 32'h0) begin errors++; $display("FAIL full_no_probe got %h want 0", ic_addr); end
        step();
        checks++; if (count !== 6'd31) begin errors++; $display("FAIL full_deq_count got %0d want 31", count); end
        checks++; if (ic_addr !== 32'h80) begin errors++; $display("FAIL resume_probe got %h want 80", ic_addr); end
        for (int k = 1; k < 32; k++) begin
            checks++; if (deq_pc !== 32'(k * 4) || count !== 6'd31) begin errors++; $display("FAIL wrap_head[%0d] got pc=%h cnt=%0d want %h/31", k, deq_pc, count, k * 4); end
            step();
        end
        checks++; if (deq_pc !== 32'h80 || count !== 6'd31) begin errors++; $display("FAIL wrap_to_zero got pc=%h cnt=%0d want 80/31", deq_pc, count); end
        do_flush(32'h40);
        $display("test_full_wrap done");
    endtask

    task automatic test_miss();
        ic_hit = 1'b0;
        checks++; if (ic_addr !== 32'h40 || mem_req !== 1'b0) begin errors++; $display("FAIL miss_probe got addr=%h req=%b want 40/0", ic_addr, mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL miss_req got req=%b addr=%h want 1/40", mem_req, mem_addr); end
        step();
        checks++; if (mem_req !== 1'b1 || ic_fill_en !== 1'b0) begin errors++; $display("FAIL miss_hold got req=%b fill=%b want 1/0", mem_req, ic_fill_en); end
        step();
        mem_ready = 1'b1; mem_inst = ADDI;
        #1;
        checks++; if (ic_fill_en !== 1'b1 || ic_fill_addr !== 32'h40 || ic_fill_inst !== ADDI) begin errors++; $display("FAIL miss_fill got en=%b addr=%h inst=%h want 1/40/%h", ic_fill_en, ic_fill_addr, ic_fill_inst, ADDI); end
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (ic_fill_en !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL miss_done got fill=%b req=%b want 0/0", ic_fill_en, mem_req); end
        checks++; if (count !== 6'd1 || deq_pc !== 32'h40 || deq_inst !== ADDI || deq_pred_pc !== 32'h44) begin errors++; $display("FAIL miss_enq got cnt=%0d pc=%h inst=%h pred=%h", count, deq_pc, deq_inst, deq_pred_pc); end
        checks++; if (ic_addr !== 32'h44) begin errors++; $display("FAIL miss_next_pc got %h want 44", ic_addr); end
        do_flush(32'h100);
        $display("test_miss done");
    endtask

    task automatic test_branch();
        ic_hit = 1'b1; ic_inst = BEQ; bht_taken = 1'b1;
        #1;
        checks++; if (bht_index !== 8'h40 || ic_addr !== 32'h100) begin errors++; $display("FAIL br_index got idx=%h addr=%h want 40/100", bht_index, ic_addr); end
        step();
        checks++; if (deq_pc !== 32'h100 || deq_pred_pc !== 32'h110 || deq_pred_taken !== 1'b1) begin errors++; $display("FAIL br_pred got pc=%h pred=%h tk=%b want 100/110/1", deq_pc, deq_pred_pc, deq_pred_taken); end
        checks++; if (ic_addr !== 32'h110 || count !== 6'd1) begin errors++; $display("FAIL br_next got addr=%h cnt=%0d want 110/1", ic_addr, count); end
        ic_inst = JAL; bht_taken = 1'b0; deq_ready = 1'b1;
        step();
        checks++; if (deq_pc !== 32'h110 || deq_pred_pc !== 32'h100 || deq_pred_taken !== 1'b1 || count !== 6'd1) begin errors++; $display("FAIL jal_pred got pc=%h pred=%h tk=%b cnt=%0d want 110/100/1/1", deq_pc, deq_pred_pc, deq_pred_taken, count); end
        do_flush(32'h80);
        $display("test_branch done");
    endtask

    task automatic test_flush_drain();
        ic_hit = 1'b0;
        checks++; if (ic_addr !== 32'h80) begin errors++; $display("FAIL drain_probe got %h want 80", ic_addr); end
        step(); step();
        flush = 1'b1; flush_pc = 32'h200;
        step();
        flush = 1'b0;
        #1;
        checks++; if (count !== 6'd0 || mem_req !== 1'b1 || mem_addr !== 32'h80 || ic_addr !== 32'h0) begin errors++; $display("FAIL drain_state got cnt=%0d req=%b maddr=%h addr=%h", count, mem_req, mem_addr, ic_addr); end
        step();
        mem_ready = 1'b1; mem_inst = ADDI;
        #1;
        checks++; if (ic_fill_en !== 1'b0) begin errors++; $display("FAIL drain_no_fill got %b want 0", ic_fill_en); end
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (count !== 6'd0 || deq_valid !== 1'b0 || mem_req !== 1'b0 || ic_addr !== 32'h200) begin errors++; $display("FAIL drain_done got cnt=%0d v=%b req=%b addr=%h want 0/0/0/200", count, deq_valid, mem_req, ic_addr); end
        // Flush coinciding with mem_ready in MISS: data dropped, straight to LOOKUP.
        step();
        flush = 1'b1; flush_pc = 32'h300; mem_ready = 1'b1;
        #1;
        checks++; if (ic_fill_en !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL flush_ready_fill got fill=%b req=%b want 0/1", ic_fill_en, mem_req); end
        step();
        flush = 1'b0; mem_ready = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || count !== 6'd0 || ic_addr !== 32'h300) begin errors++; $display("FAIL flush_ready_next got req=%b cnt=%0d addr=%h want 0/0/300", mem_req, count, ic_addr); end
        $display("test_flush_drain done");
    endtask

    task automatic test_jalr();
        ic_hit = 1'b1; ic_inst = JALR;
        step();
        checks++; if (count !== 6'd1 || deq_pc !== 32'h300 || deq_pred_pc !== 32'h304 || deq_pred_taken !== 1'b0) begin errors++; $display("FAIL jalr_enq got cnt=%0d pc=%h pred=%h tk=%b", count, deq_pc, deq_pred_pc, deq_pred_taken); end
        ic_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ic_addr !== 32'h0 || mem_req !== 1'b0 || count !== 6'd1) begin errors++; $display("FAIL jalr_halt[%0d] got addr=%h req=%b cnt=%0d want 0/0/1", i, ic_addr, mem_req, count); end
            step();
        end
        do_flush(32'h400);
        checks++; if (ic_addr !== 32'h400 || count !== 6'd0) begin errors++; $display("FAIL jalr_resume got addr=%h cnt=%0d want 400/0", ic_addr, count); end
        $display("test_jalr done");
    endtask

    task automatic test_rdy();
        rdy = 1'b0; ic_hit = 1'b1; ic_inst = NOP;
        step(); step();
        checks++; if (count !== 6'd0 || ic_addr !== 32'h400) begin errors++; $display("FAIL rdy_freeze got cnt=%0d addr=%h want 0/400", count, ic_addr); end
        rdy = 1'b1;
        step();
        checks++; if (count !== 6'd1 || deq_pc !== 32'h400 || ic_addr !== 32'h404) begin errors++; $display("FAIL rdy_resume got cnt=%0d pc=%h addr=%h want 1/400/404", count, deq_pc, ic_addr); end
        $display("test_rdy done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_wrap();
        test_miss();
        test_branch();
        test_flush_drain();
        test_jalr();
        test_rdy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-issue instruction queue.
- Fetches instructions from the icache, or from the memory controller on an icache miss, and predecodes them.
- Predicts the next PC for JAL and conditional branches using the BHT.
- Buffers fetched instructions in a DEPTH-entry circular queue. The dispatch stage drains it through a valid/ready handshake.
- Adds a flush-safe miss drain and JALR fetch halt, which the previous queue lacked.

Parameters:
DEPTH, 32, queue entries; power of two, ≥2
BHT_IDX_W, 8, BHT index width; index = pc[BHT_IDX_W+1:2]
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
flush  in  1  mispredict redirect
flush_pc  in  32  redirect target
ic_addr  out  32  icache probe address (comb)
ic_hit  in  1  probe hit (comb)
ic_inst  in  32  hit data
ic_fill_en  out  1  write returned miss data to icache
ic_fill_addr  out  32  fill address
ic_fill_inst  out  32  fill data
mem_req  out  1  miss request, held until mem_ready
mem_addr  out  32  miss address
mem_ready  in  1  miss data valid (one-cycle pulse)
mem_inst  in  32  miss data
bht_index  out  BHT_IDX_W  BHT lookup index (comb)
bht_taken  in  1  prediction (comb)
deq_valid  out  1  head entry valid
deq_ready  in  1  dispatcher accepts head
deq_inst  out  32  head instruction
deq_pc  out  32  head PC
deq_pred_pc  out  32  head predicted next PC
deq_pred_taken  out  1  head predicted taken
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: pc=RESET_PC, head=tail=0, count=0, state=LOOKUP. All outputs 0.
- rdy=0: no register updates; combinational outputs still reflect current state.
- FSM states:
  - LOOKUP: when count<DEPTH, ic_addr=pc. On ic_hit, enqueue in the same cycle. On a miss, go to MISS; mem_req/mem_addr register high/pc from the next cycle.
  - MISS: hold mem_req. On mem_ready, enqueue mem_inst, pulse ic_fill_* for one cycle (addr=pc), return to LOOKUP.
  - DRAIN: entered on flush while in MISS. Hold mem_req until mem_ready, discard the data (no enqueue, no fill), then go to LOOKUP.
  - HALT: entered after enqueuing a JALR (opcode 7'h67). No fetch until flush.
- Next PC on enqueue, by opcode:
  - JAL (7'h6f): pc+immJ; pred_taken=1.
  - Branch (7'h63): bht_index from the fetched pc. bht_taken → pc+immB, pred_taken=1; otherwise pc+4.
  - JALR: pc+4 recorded; pred_taken=0.
  - Other: pc+4.
- All PC arithmetic is 32-bit wrap. Immediates are sign-extended.
- Dequeue: deq_valid=(count≠0); the head fields come from the head entry. deq_valid&&deq_ready advances head.
- Simultaneous enqueue and dequeue: count unchanged.
- Full (count==DEPTH): no probe, no request; state stays LOOKUP.
- head/tail wrap modulo DEPTH.
- flush (has priority over enq/deq): head=tail=count=0, pc=flush_pc. State becomes LOOKUP, or DRAIN if in MISS or DRAIN. Flush in the same cycle as mem_ready while in MISS: data is discarded and the next state is LOOKUP.
- rst overrides flush.

Optional Feature:
FQ_PERF_EN:
- Defined: adds outputs perf_miss_cnt[31:0] (increments on each LOOKUP→MISS) and perf_full_cnt[31:0] (increments per cycle with count==DEPTH while rdy). Both reset to 0, are not cleared by flush, and saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters are absent.

Decomposition:
- Package fq_pkg:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH
  - state enum {LOOKUP, MISS, DRAIN, HALT}
  - queue entry struct {inst, pc, pred_pc, pred_taken}
  - imm_j/imm_b extraction functions
- One sub-module, fq_predecode (combinational): inst, pc, bht_taken → next_pc, pred_taken, is_branch, is_jalr.

Test Plan:
- Reset, then ic_hit=1 with NOPs (32'h00000013) every cycle, deq_ready=0 → 32 enqueues with pcs 0..124, count=32. Fetch then stops, ic_addr is don't-care, no mem_req.
- Miss at pc=0x40, mem_ready on the 3rd cycle with 32'h00500093 → one ic_fill pulse (addr 0x40), entry enqueued, pc=0x44.
- Branch at 0x100 with immB=+16 and bht_taken=1 → bht_index=0x40, next pc=0x110, deq_pred_taken=1, deq_pred_pc=0x110.
- flush (flush_pc=0x200) while in MISS at 0x80 → count=0. mem_req is held, returned data is dropped (no fill, no enqueue), then the first probe is 0x200.
- JALR enqueued at 0x300 → no further probe or request until flush; flush_pc=0x400 resumes fetch at 0x400.
- Queue full with deq_ready=1 and ic_hit=1 → no enqueue while full. Next cycle, an enqueue coincides with a dequeue and count stays at 31. Head index wraps from 31 to 0.
